// File: rtl/riscv_dram_arbiter.sv
// riscv_dram_arbiter: shares one DRAM port between the I-side (fetch/refill)
// and D-side (load/store/refill) requesters. Round-robin on ties, one
// transaction at a time, registered outputs, and a watchdog that turns a
// missing mem_ready into a completed transaction plus a sticky error flag.
module riscv_dram_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 128,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    // I-side requester (read only)
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic [DATA_W-1:0] ic_rdata,
    output logic              ic_done,
    // D-side requester (read or write)
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              dc_done,
    // DRAM port
    output logic              mem_rden,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    // Sticky watchdog flag
    output logic              timeout_err
);

    // TIMEOUT >= 8, so this width always holds TIMEOUT-1.
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY_IC = 2'd1,
        S_BUSY_DC = 2'd2,
        S_RESP    = 2'd3
    } state_e;

    // last_grant encoding: 0 = I-side, 1 = D-side
    localparam logic GRANT_IC = 1'b0;
    localparam logic GRANT_DC = 1'b1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              mem_rden_q, mem_rden_d;
    logic              mem_wren_q, mem_wren_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] ic_rdata_q, ic_rdata_d;
    logic [DATA_W-1:0] dc_rdata_q, dc_rdata_d;
    logic              ic_done_q, ic_done_d;
    logic              dc_done_q, dc_done_d;
    logic              timeout_err_q, timeout_err_d;

    logic grant_ic;
    logic grant_dc;
    logic timed_out;
    logic txn_end;

    // On a tie the side that did not win last time is served, so D wins the
    // first tie after reset (last_grant resets to I-side).
    assign grant_dc  = dc_req && (!ic_req || (last_grant_q == GRANT_IC));
    assign grant_ic  = ic_req && (!dc_req || (last_grant_q == GRANT_DC));
    // mem_ready wins if it arrives on the very cycle the watchdog expires.
    assign timed_out = !mem_ready && (wait_cnt_q == WAIT_LAST);
    assign txn_end   = mem_ready || timed_out;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge value of every other register.
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> BUSY_x -> RESP -> IDLE.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned
        // (an unassigned path in always_comb infers a latch).
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (grant_dc) begin
                    state_d = S_BUSY_DC;
                end else if (grant_ic) begin
                    state_d = S_BUSY_IC;
                end
            end
            S_BUSY_IC,
            S_BUSY_DC: begin
                if (txn_end) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output/datapath next values: latch request on grant, count the wait,
    // capture read data and pulse done when the beat completes or times out.
    always_comb begin
        wait_cnt_d    = wait_cnt_q;
        last_grant_d  = last_grant_q;
        mem_rden_d    = mem_rden_q;
        mem_wren_d    = mem_wren_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        ic_rdata_d    = ic_rdata_q;
        dc_rdata_d    = dc_rdata_q;
        ic_done_d     = 1'b0;
        dc_done_d     = 1'b0;
        timeout_err_d = timeout_err_q;

        unique case (state_q)
            S_IDLE: begin
                if (grant_dc) begin
                    mem_addr_d   = dc_addr;
                    mem_wdata_d  = dc_wdata;
                    mem_wren_d   = dc_we;
                    mem_rden_d   = !dc_we;
                    last_grant_d = GRANT_DC;
                    wait_cnt_d   = '0;
                end else if (grant_ic) begin
                    mem_addr_d   = ic_addr;
                    mem_wren_d   = 1'b0;
                    mem_rden_d   = 1'b1;
                    last_grant_d = GRANT_IC;
                    wait_cnt_d   = '0;
                end
            end
            S_BUSY_IC: begin
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
                if (txn_end) begin
                    mem_rden_d = 1'b0;
                    mem_wren_d = 1'b0;
                    ic_done_d  = 1'b1;
                    ic_rdata_d = timed_out ? '0 : mem_rdata;
                    if (timed_out) begin
                        timeout_err_d = 1'b1;
                    end
                end
            end
            S_BUSY_DC: begin
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
                if (txn_end) begin
                    mem_rden_d = 1'b0;
                    mem_wren_d = 1'b0;
                    dc_done_d  = 1'b1;
                    // Writes leave the D-side read data untouched.
                    if (!mem_wren_q) begin
                        dc_rdata_d = timed_out ? '0 : mem_rdata;
                    end
                    if (timed_out) begin
                        timeout_err_d = 1'b1;
                    end
                end
            end
            default: begin
                // RESP: done stays visible this cycle and clears on exit.
            end
        endcase
    end

    // Datapath/output registers; all cleared by reset, even mid-transaction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_q    <= '0;
            last_grant_q  <= GRANT_IC;
            mem_rden_q    <= 1'b0;
            mem_wren_q    <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            ic_rdata_q    <= '0;
            dc_rdata_q    <= '0;
            ic_done_q     <= 1'b0;
            dc_done_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            last_grant_q  <= last_grant_d;
            mem_rden_q    <= mem_rden_d;
            mem_wren_q    <= mem_wren_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            ic_rdata_q    <= ic_rdata_d;
            dc_rdata_q    <= dc_rdata_d;
            ic_done_q     <= ic_done_d;
            dc_done_q     <= dc_done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign mem_rden    = mem_rden_q;
    assign mem_wren    = mem_wren_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign ic_rdata    = ic_rdata_q;
    assign dc_rdata    = dc_rdata_q;
    assign ic_done     = ic_done_q;
    assign dc_done     = dc_done_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_riscv_dram_arbiter.sv
// Directed testbench for riscv_dram_arbiter with a 4-cycle DRAM latency
// model. Inputs change and outputs are sampled on the falling edge.
module tb_riscv_dram_arbiter;

    localparam int ADDR_W  = 64;
    localparam int DATA_W  = 128;
    localparam int TIMEOUT = 16;

    logic              clk;
    logic              rst_n;
    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic [DATA_W-1:0] ic_rdata;
    logic              ic_done;
    logic              dc_req;
    logic              dc_we;
    logic [ADDR_W-1:0] dc_addr;
    logic [DATA_W-1:0] dc_wdata;
    logic [DATA_W-1:0] dc_rdata;
    logic              dc_done;
    logic              mem_rden;
    logic              mem_wren;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              timeout_err;

    int tests_run    = 0;
    int tests_failed = 0;

    // DRAM latency model controls
    logic [DATA_W-1:0] model_rdata;
    logic              mem_stall;
    int                lat_cnt;

    // Protocol monitors
    logic [ADDR_W-1:0] grant_q[$];
    logic              en_prev;
    int                overlap_done;
    int                overlap_en;

    riscv_dram_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ic_req     (ic_req),
        .ic_addr    (ic_addr),
        .ic_rdata   (ic_rdata),
        .ic_done    (ic_done),
        .dc_req     (dc_req),
        .dc_we      (dc_we),
        .dc_addr    (dc_addr),
        .dc_wdata   (dc_wdata),
        .dc_rdata   (dc_rdata),
        .dc_done    (dc_done),
        .mem_rden   (mem_rden),
        .mem_wren   (mem_wren),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DRAM model: mem_ready rises 4 edges after an enable is first seen,
    // lasts one cycle, and never rises while stalled or with enables low.
    assign mem_rdata = model_rdata;
    always @(posedge clk) begin
        if (!(mem_rden || mem_wren) || mem_stall) begin
            lat_cnt   <= 0;
            mem_ready <= 1'b0;
        end else if (mem_ready) begin
            lat_cnt   <= 0;
            mem_ready <= 1'b0;
        end else begin
            lat_cnt   <= lat_cnt + 1;
            mem_ready <= (lat_cnt == 3);
        end
    end

    // Record the address of every new grant; count forbidden overlaps.
    always @(negedge clk) begin
        if ((mem_rden || mem_wren) && !en_prev) grant_q.push_back(mem_addr);
        en_prev = mem_rden || mem_wren;
        if (ic_done && dc_done) overlap_done++;
        if (mem_rden && mem_wren) overlap_en++;
    end

    task automatic test_reset();
        int done_n;
        rst_n = 1'b0; ic_req = 1'b1; dc_req = 1'b1; dc_we = 1'b0;
        ic_addr = 64'h80; dc_addr = 64'h1000; dc_wdata = 128'h0;
        model_rdata = 128'h1111;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({mem_rden, mem_wren, ic_done, dc_done, timeout_err} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b, expected 00000",
                     {mem_rden, mem_wren, ic_done, dc_done, timeout_err});
        end
        tests_run++;
        if ({mem_addr, mem_wdata} !== '0) begin
            tests_failed++;
            $display("FAIL reset_mem_bus: got addr %0h wdata %0h, expected 0", mem_addr, mem_wdata);
        end
        tests_run++;
        if ({ic_rdata, dc_rdata} !== '0) begin
            tests_failed++;
            $display("FAIL reset_rdata: got ic %0h dc %0h, expected 0", ic_rdata, dc_rdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({mem_rden, mem_wren, mem_addr} !== {1'b1, 1'b0, 64'h1000}) begin
            tests_failed++;
            $display("FAIL reset_first_tie_d: got rden %b wren %b addr %0h, expected 1 0 1000",
                     mem_rden, mem_wren, mem_addr);
        end
        ic_req = 1'b0;
        done_n = 0;
        for (int n = 2; n <= 12; n++) begin
            @(negedge clk);
            if (dc_done) begin
                done_n = n;
                dc_req = 1'b0;
                break;
            end
        end
        tests_run++;
        if (done_n !== 6 || dc_rdata !== 128'h1111) begin
            tests_failed++;
            $display("FAIL reset_first_dc_read: got done at %0d rdata %0h, expected 6 1111",
                     done_n, dc_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_single_ic();
        int rden_cnt = 0, wren_cnt = 0, done_cnt = 0, done_n = 0;
        logic [ADDR_W-1:0] addr1 = '0;
        logic [DATA_W-1:0] rd = '0;
        ic_addr = 64'h80; model_rdata = 128'hA5A5; ic_req = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) addr1 = mem_addr;
            if (mem_rden) rden_cnt++;
            if (mem_wren) wren_cnt++;
            if (ic_done) begin
                done_cnt++;
                if (done_n == 0) begin
                    done_n = n;
                    rd = ic_rdata;
                    ic_req = 1'b0;
                end
            end
        end
        tests_run++;
        if (addr1 !== 64'h80) begin
            tests_failed++;
            $display("FAIL ic_addr: got %0h, expected 80", addr1);
        end
        tests_run++;
        if (rden_cnt !== 5 || wren_cnt !== 0) begin
            tests_failed++;
            $display("FAIL ic_enables: got rden %0d wren %0d cycles, expected 5 0", rden_cnt, wren_cnt);
        end
        tests_run++;
        if (done_n !== 6 || done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL ic_done_timing: got at %0d width %0d, expected 6 1", done_n, done_cnt);
        end
        tests_run++;
        if (rd !== 128'hA5A5) begin
            tests_failed++;
            $display("FAIL ic_rdata: got %0h, expected a5a5", rd);
        end
    endtask

    task automatic test_tie();
        int dc_done_n = 0, ic_grant_n = 0, ic_done_n = 0;
        logic [DATA_W-1:0] wd1 = '0, ic_rd = '0;
        logic [ADDR_W-1:0] addr1 = '0;
        logic rden1 = 1'b0, wren1 = 1'b0;
        ic_addr = 64'h100; dc_addr = 64'h2000; dc_we = 1'b1; dc_wdata = 128'h1234;
        model_rdata = 128'h5A5A;
        ic_req = 1'b1; dc_req = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (n == 1) begin
                rden1 = mem_rden; wren1 = mem_wren; wd1 = mem_wdata; addr1 = mem_addr;
            end
            if (dc_done && dc_done_n == 0) begin
                dc_done_n = n;
                dc_req = 1'b0;
            end
            if (mem_rden && mem_addr == 64'h100 && ic_grant_n == 0) ic_grant_n = n;
            if (ic_done && ic_done_n == 0) begin
                ic_done_n = n;
                ic_rd = ic_rdata;
                ic_req = 1'b0;
            end
        end
        tests_run++;
        if ({rden1, wren1, addr1, wd1} !== {1'b0, 1'b1, 64'h2000, 128'h1234}) begin
            tests_failed++;
            $display("FAIL tie_d_write: got rden %b wren %b addr %0h wdata %0h, expected 0 1 2000 1234",
                     rden1, wren1, addr1, wd1);
        end
        tests_run++;
        if (dc_done_n !== 6 || ic_grant_n !== 8) begin
            tests_failed++;
            $display("FAIL tie_ic_after_d: got dc_done %0d ic_grant %0d, expected 6 8",
                     dc_done_n, ic_grant_n);
        end
        tests_run++;
        if (ic_done_n !== 13 || ic_rd !== 128'h5A5A) begin
            tests_failed++;
            $display("FAIL tie_ic_read: got done %0d rdata %0h, expected 13 5a5a", ic_done_n, ic_rd);
        end
        tests_run++;
        if (dc_rdata !== 128'h1111) begin
            tests_failed++;
            $display("FAIL tie_write_keeps_rdata: got %0h, expected 1111", dc_rdata);
        end
    endtask

    task automatic test_fairness();
        int dones = 0;
        logic [ADDR_W-1:0] exp_a, got_a;
        ic_addr = 64'h300; dc_addr = 64'h4000; dc_we = 1'b0; model_rdata = 128'h2222;
        grant_q.delete();
        ic_req = 1'b1; dc_req = 1'b1;
        for (int n = 1; n <= 80; n++) begin
            @(negedge clk);
            if (ic_done || dc_done) dones++;
            if (dones == 6) begin
                ic_req = 1'b0; dc_req = 1'b0;
                break;
            end
        end
        @(negedge clk);
        tests_run++;
        if (dones !== 6 || grant_q.size() !== 6) begin
            tests_failed++;
            $display("FAIL fair_count: got %0d dones %0d grants, expected 6 6", dones, grant_q.size());
        end
        for (int i = 0; i < 6; i++) begin
            exp_a = (i % 2 == 0) ? 64'h4000 : 64'h300;
            got_a = (i < grant_q.size()) ? grant_q[i] : '1;
            tests_run++;
            if (got_a !== exp_a) begin
                tests_failed++;
                $display("FAIL fair_grant_%0d: got addr %0h, expected %0h", i, got_a, exp_a);
            end
        end
    endtask

    task automatic test_watchdog();
        int rden_cnt = 0, done_n = 0;
        tests_run++;
        if (timeout_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL wd_err_before: got %b, expected 0", timeout_err);
        end
        mem_stall = 1'b1; model_rdata = 128'h9999;
        dc_addr = 64'h5000; dc_we = 1'b0; dc_req = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (mem_rden) rden_cnt++;
            if (dc_done) begin
                done_n = n;
                dc_req = 1'b0;
                break;
            end
        end
        tests_run++;
        if (done_n !== TIMEOUT + 1 || rden_cnt !== TIMEOUT) begin
            tests_failed++;
            $display("FAIL wd_timing: got done %0d busy %0d, expected %0d %0d",
                     done_n, rden_cnt, TIMEOUT + 1, TIMEOUT);
        end
        tests_run++;
        if (dc_rdata !== '0 || timeout_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL wd_result: got rdata %0h err %b, expected 0 1", dc_rdata, timeout_err);
        end
        @(negedge clk);
        mem_stall = 1'b0;
        ic_addr = 64'h600; model_rdata = 128'hBEEF; ic_req = 1'b1;
        done_n = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (ic_done) begin
                done_n = n;
                ic_req = 1'b0;
                break;
            end
        end
        tests_run++;
        if (done_n !== 6 || ic_rdata !== 128'hBEEF || timeout_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL wd_recover: got done %0d rdata %0h err %b, expected 6 beef 1",
                     done_n, ic_rdata, timeout_err);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_busy();
        int done_cnt = 0, done_n = 0;
        logic rden1 = 1'b0;
        ic_addr = 64'h700; model_rdata = 128'h7777; ic_req = 1'b1;
        @(negedge clk);
        rden1 = mem_rden;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({rden1, mem_rden, mem_wren, timeout_err} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL mid_reset_drop: got rden_before %b rden %b wren %b err %b, expected 1 0 0 0",
                     rden1, mem_rden, mem_wren, timeout_err);
        end
        if (ic_done) done_cnt++;
        ic_req = 1'b0; rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (ic_done) done_cnt++;
        end
        tests_run++;
        if (done_cnt !== 0) begin
            tests_failed++;
            $display("FAIL mid_reset_no_done: got %0d pulses, expected 0", done_cnt);
        end
        ic_addr = 64'h780; model_rdata = 128'h7878; ic_req = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (ic_done) begin
                done_n = n;
                ic_req = 1'b0;
                break;
            end
        end
        tests_run++;
        if (done_n !== 6 || ic_rdata !== 128'h7878) begin
            tests_failed++;
            $display("FAIL mid_reset_recover: got done %0d rdata %0h, expected 6 7878", done_n, ic_rdata);
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
        ic_addr = '0; dc_addr = '0; dc_wdata = '0;
        model_rdata = '0; mem_stall = 1'b0; mem_ready = 1'b0; lat_cnt = 0;
        en_prev = 1'b0; overlap_done = 0; overlap_en = 0;

        test_reset();
        test_single_ic();
        test_tie();
        test_fairness();
        test_watchdog();
        test_reset_mid_busy();

        tests_run++;
        if (overlap_done !== 0) begin
            tests_failed++;
            $display("FAIL done_exclusive: got %0d overlapping cycles, expected 0", overlap_done);
        end
        tests_run++;
        if (overlap_en !== 0) begin
            tests_failed++;
            $display("FAIL enable_exclusive: got %0d overlapping cycles, expected 0", overlap_en);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
